// File: rtl/sram_ring_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ring_buffer_if
// Purpose  : Bundles the three handshake channels of sram_ring_buffer:
//            input sample stream, output sample stream and the request /
//            return channel towards sram_arbiter (user channel 0).
// Ports    : (interface signals)
//   s_data/s_valid/s_ready        input stream, ready/valid
//   m_data/m_valid/m_ready        output stream, ready/valid
//   arb_addr/arb_data_wr/arb_we   request payload to the arbiter
//   arb_en/arb_busy               request handshake (accepted on en & !busy)
//   arb_data_rd/arb_valid         in-order read return from the arbiter
// Modports : master = ring buffer side, slave = environment side
// Revision : 1.0 - initial release
// ============================================================================
interface sram_ring_buffer_if #(
  parameter int aw = 19,
  parameter int dw = 8
);
  logic [dw-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [dw-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [aw-1:0] arb_addr;
  logic [dw-1:0] arb_data_wr;
  logic [dw-1:0] arb_data_rd;
  logic          arb_en;
  logic          arb_busy;
  logic          arb_we;
  logic          arb_valid;

  modport master (
    input  s_data, s_valid, m_ready, arb_data_rd, arb_busy, arb_valid,
    output s_ready, m_data, m_valid, arb_addr, arb_data_wr, arb_en, arb_we
  );

  modport slave (
    output s_data, s_valid, m_ready, arb_data_rd, arb_busy, arb_valid,
    input  s_ready, m_data, m_valid, arb_addr, arb_data_wr, arb_en, arb_we
  );
endinterface
`default_nettype wire

// File: rtl/sram_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sram_ring_buffer
// Purpose  : Stream FIFO that uses an external SRAM (behind sram_arbiter) as a
//            2**aw word circular buffer, with a small first-word-fall-through
//            output FIFO refilled by in-order SRAM reads.
// Ports    :
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   en     in   gates new arbiter requests (in-flight work still completes)
//   bus    if   sram_ring_buffer_if.master: input/output streams + arbiter
//   level  out  words committed to SRAM and not yet read-requested (aw+1 b)
//   err    out  sticky: read return seen with no read outstanding
// Revision : 1.0 - initial release
// ============================================================================
module sram_ring_buffer #(
  parameter int aw        = 19,
  parameter int dw        = 8,
  parameter int out_depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  sram_ring_buffer_if.master   bus,
  output logic [aw:0]          level,
  output logic                 err
);

  localparam int pw = $clog2(out_depth);   // output FIFO index width
  localparam int cw = pw + 1;              // counts 0..out_depth
  localparam logic [cw:0] depth_lim = (cw+1)'(out_depth);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]    state;
  logic          in_full;
  logic [dw-1:0] in_data;
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [cw-1:0] outstanding;
  logic [cw-1:0] out_count;
  logic [dw-1:0] out_mem [out_depth];
  logic [pw-1:0] out_head;
  logic [pw-1:0] out_tail;
  logic          last_grant_rd;

  logic          accept;
  logic          wr_acc;
  logic          rd_acc;
  logic          load;
  logic          ret_ok;
  logic          pop;
  logic [cw:0]   credit_used;
  logic          wr_elig;
  logic          rd_elig;
  logic          grant_rd;

  assign accept   = bus.arb_en & ~bus.arb_busy;
  assign wr_acc   = accept & (state == WR);
  assign rd_acc   = accept & (state == RD);
  assign load     = bus.s_valid & ~in_full;
  assign ret_ok   = bus.arb_valid & (outstanding != '0);
  assign pop      = (out_count != '0) & bus.m_ready;

  // Reads in flight plus words already buffered must fit in the output FIFO,
  // so a read is only issued when a slot is guaranteed for its return.
  assign credit_used = {1'b0, outstanding} + {1'b0, out_count};
  assign wr_elig     = en & in_full & ~level[aw];
  assign rd_elig     = en & (level != '0) & (credit_used < depth_lim);
  // Round-robin on contention; otherwise whichever side is eligible.
  assign grant_rd    = rd_elig & (~wr_elig | ~last_grant_rd);

  assign bus.s_ready = ~in_full;
  assign bus.m_valid = (out_count != '0);
  assign bus.m_data  = out_mem[out_head];

  // Request FSM and buffer bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bus.arb_en      <= 1'b0;
      bus.arb_we      <= 1'b0;
      bus.arb_addr    <= '0;
      bus.arb_data_wr <= '0;
      last_grant_rd   <= 1'b1;     // so the first contention goes to the write
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      in_full         <= 1'b0;
      in_data         <= '0;
      outstanding     <= '0;
      err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_elig | rd_elig) begin
            bus.arb_en <= 1'b1;
            if (grant_rd) begin
              state         <= RD;
              bus.arb_we    <= 1'b0;
              bus.arb_addr  <= rd_ptr;
              last_grant_rd <= 1'b1;
            end else begin
              state           <= WR;
              bus.arb_we      <= 1'b1;
              bus.arb_addr    <= wr_ptr;
              bus.arb_data_wr <= in_data;
              last_grant_rd   <= 1'b0;
            end
          end
        end
        WR: begin
          if (accept) begin
            state      <= IDLE;
            bus.arb_en <= 1'b0;
            bus.arb_we <= 1'b0;
            wr_ptr     <= wr_ptr + 1'b1;
          end
        end
        RD: begin
          if (accept) begin
            state      <= IDLE;
            bus.arb_en <= 1'b0;
            rd_ptr     <= rd_ptr + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          bus.arb_en <= 1'b0;
          bus.arb_we <= 1'b0;
        end
      endcase

      // Write and read acceptances never coincide (one request at a time).
      if (wr_acc)
        level <= level + 1'b1;
      else if (rd_acc)
        level <= level - 1'b1;

      if (load) begin
        in_full <= 1'b1;
        in_data <= bus.s_data;
      end else if (wr_acc) begin
        in_full <= 1'b0;
      end

      case ({rd_acc, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (bus.arb_valid && (outstanding == '0))
        err <= 1'b1;
    end
  end

  // Output FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_count <= '0;
      out_head  <= '0;
      out_tail  <= '0;
      for (int i = 0; i < out_depth; i++)
        out_mem[i] <= '0;
    end else begin
      if (ret_ok) begin
        out_mem[out_tail] <= bus.arb_data_rd;
        out_tail          <= out_tail + 1'b1;
      end
      if (pop)
        out_head <= out_head + 1'b1;
      case ({ret_ok, pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ring_buffer
// Purpose  : Self-checking bench for sram_ring_buffer (aw=4, dw=8, depth 4).
//            Contains a behavioural SRAM/arbiter responder (random busy,
//            random in-order latency) and a stream scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ring_buffer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int OD = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [AW:0]   level;
  logic          err;

  sram_ring_buffer_if #(.aw(AW), .dw(DW)) bus ();

  sram_ring_buffer #(.aw(AW), .dw(DW), .out_depth(OD)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .bus   (bus),
    .level (level),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } ret_t;

  int            compared   = 0;
  int            mismatched = 0;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] src [$];    // samples still to be offered
  logic [DW-1:0] wq  [$];    // samples taken in, not yet written to SRAM
  logic [DW-1:0] expq[$];    // samples expected on the output, in order
  ret_t          rq  [$];    // read returns scheduled by the SRAM model
  int            wr_cnt, rd_cnt, delivered, popped, cyc, last_due, total_in;
  bit            hold, err_exp, spurious, prev_stall, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  int            busy_mode, mready_mode, max_lat, first_wr_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    src.delete(); wq.delete(); expq.delete(); rq.delete();
    wr_cnt = 0; rd_cnt = 0; delivered = 0; popped = 0; last_due = 0;
    total_in = 0; hold = 0; err_exp = 0; spurious = 0; prev_stall = 0;
    first_wr_addr = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arb_en"},  32'(bus.arb_en), 0);
    check({tag, "_arb_we"},  32'(bus.arb_we), 0);
    check({tag, "_arb_addr"}, 32'(bus.arb_addr), 0);
    check({tag, "_arb_dwr"}, 32'(bus.arb_data_wr), 0);
    check({tag, "_level"},   32'(level), 0);
    check({tag, "_err"},     32'(err), 0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 1);
  endtask

  // One clock: check DUT state against the model, then drive the next cycle.
  task automatic step();
    ret_t          r;
    logic [DW-1:0] v;
    int            lat;
    @(negedge clk);
    cyc++;
    check("level",   32'(level), 32'(wr_cnt - rd_cnt));
    check("s_ready", 32'(bus.s_ready), 32'(!hold));
    check("m_valid", 32'(bus.m_valid), 32'((delivered - popped) > 0));
    check("err",     32'(err), 32'(err_exp));
    if (prev_stall) begin
      check("stall_en",   32'(bus.arb_en), 1);
      check("stall_addr", 32'(bus.arb_addr), 32'(prev_addr));
      check("stall_we",   32'(bus.arb_we), 32'(prev_we));
      check("stall_data", 32'(bus.arb_data_wr), 32'(prev_data));
    end

    // downstream consumer
    case (mready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b1;
    endcase
    if (bus.m_ready && (delivered > popped)) begin
      check("m_data", 32'(bus.m_data), 32'(expq.pop_front()));
      popped++;
    end

    // upstream producer (uses the pre-edge holding state)
    bus.s_valid = (src.size() > 0) && ($urandom_range(0, 3) != 0);
    bus.s_data  = (src.size() > 0) ? src[0] : DW'($urandom);
    if (bus.s_valid && !hold) begin
      v = src.pop_front();
      wq.push_back(v);
      expq.push_back(v);
      hold = 1;
    end

    // SRAM / arbiter responder
    case (busy_mode)
      0:       bus.arb_busy = 1'b0;
      1:       bus.arb_busy = ($urandom_range(0, 2) == 0);
      default: bus.arb_busy = 1'b1;
    endcase
    prev_stall = bus.arb_en && bus.arb_busy;
    prev_addr  = bus.arb_addr;
    prev_we    = bus.arb_we;
    prev_data  = bus.arb_data_wr;
    if (bus.arb_en && !bus.arb_busy) begin
      if (bus.arb_we) begin
        check("wr_addr", 32'(bus.arb_addr), 32'(wr_cnt % N));
        if (wq.size() == 0) check("wr_spurious", 1, 0);
        else                check("wr_data", 32'(bus.arb_data_wr), 32'(wq.pop_front()));
        if (first_wr_addr < 0) first_wr_addr = int'(bus.arb_addr);
        mem[bus.arb_addr] = bus.arb_data_wr;
        wr_cnt++;
        hold = 0;
      end else begin
        check("rd_addr", 32'(bus.arb_addr), 32'(rd_cnt % N));
        check("rd_after_wr", 32'(rd_cnt < wr_cnt), 1);
        rd_cnt++;
        check("rd_credit", 32'((rd_cnt - popped) <= OD), 1);
        lat   = $urandom_range(1, max_lat);
        r.d   = mem[bus.arb_addr];
        r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = r.due;
        rq.push_back(r);
      end
    end
    if (spurious) begin
      bus.arb_valid   = 1'b1;
      bus.arb_data_rd = 8'hEE;
      spurious = 0;
      err_exp  = 1;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      bus.arb_valid   = 1'b1;
      bus.arb_data_rd = r.d;
      delivered++;
    end else begin
      bus.arb_valid   = 1'b0;
      bus.arb_data_rd = DW'($urandom);
    end
  endtask

  task automatic push_words(input int n, input bit counting);
    for (int i = 0; i < n; i++) begin
      src.push_back(counting ? DW'(i + 1) : DW'($urandom));
      total_in++;
    end
  endtask

  task automatic drain(input string tag);
    en = 1'b1; mready_mode = 1; busy_mode = 1;
    for (int i = 0; i < 2000 && popped < total_in; i++) step();
    check({tag, "_drained"}, 32'(popped), 32'(total_in));
    repeat (4) step();
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus.arb_busy = 1'b0; bus.arb_valid = 1'b0; bus.arb_data_rd = '0;
    cyc = 0; busy_mode = 0; mready_mode = 0; max_lat = 1;
    for (int i = 0; i < N; i++) mem[i] = '0;
    model_reset();

    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Phase 1: five counting samples, consumer stalled, then released
    en = 1'b1; busy_mode = 0; max_lat = 1; mready_mode = 0;
    push_words(5, 1'b1);
    repeat (60) step();
    check("p1_level", 32'(level), 1);
    check("p1_buffered", 32'(delivered - popped), OD);
    check("p1_head", 32'(bus.m_data), 8'h01);
    check("p1_first_wr_addr", 32'(first_wr_addr), 0);
    mready_mode = 2;
    for (int i = 0; i < 200 && popped < 5; i++) step();
    check("p1_popped", 32'(popped), 5);
    repeat (3) step();
    check("p1_level_end", 32'(level), 0);

    // Phase 2: fill to capacity with the consumer stalled
    busy_mode = 1; max_lat = 3; mready_mode = 0;
    push_words(24, 1'b0);
    repeat (300) step();
    check("p2_level_full", 32'(level), 32'(N));
    check("p2_s_ready", 32'(bus.s_ready), 0);
    check("p2_left", 32'(src.size()), 3);
    check("p2_buffered", 32'(delivered - popped), OD);
    en = 1'b0; mready_mode = 1;
    repeat (12) step();
    check("p2_en_off", 32'(bus.arb_en), 0);
    drain("p2");

    // Phase 3: wrap-around streaming
    mready_mode = 2; busy_mode = 0; max_lat = 3;
    push_words(40, 1'b0);
    for (int i = 0; i < 1500 && popped < total_in; i++) step();
    check("p3_popped", 32'(popped), 32'(total_in));
    check("p3_wrapped", 32'(wr_cnt > N), 1);
    check("p3_err", 32'(err), 0);

    // Phase 4: write request held off by arbiter busy for 5 cycles
    busy_mode = 2; mready_mode = 0;
    push_words(1, 1'b0);
    for (int i = 0; i < 20 && !bus.arb_en; i++) step();
    check("p4_req", 32'(bus.arb_en), 1);
    check("p4_we", 32'(bus.arb_we), 1);
    en = 1'b0;
    begin
      int w0;
      w0 = wr_cnt;
      repeat (5) step();
      check("p4_no_accept", 32'(wr_cnt), 32'(w0));
      busy_mode = 0;
      repeat (4) step();
      check("p4_one_accept", 32'(wr_cnt), 32'(w0 + 1));
      check("p4_level", 32'(level), 1);
      check("p4_idle", 32'(bus.arb_en), 0);
    end
    drain("p4");

    // Phase 5: spurious return with nothing outstanding
    en = 1'b0; mready_mode = 0; busy_mode = 0;
    spurious = 1;
    repeat (4) step();
    check("p5_err_sticky", 32'(err), 1);
    check("p5_m_valid", 32'(bus.m_valid), 0);

    // Phase 6: asynchronous reset in the middle of traffic
    en = 1'b1; busy_mode = 1; max_lat = 2;
    push_words(6, 1'b0);
    repeat (15) step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async");
    bus.s_valid = 1'b0; bus.arb_valid = 1'b0; bus.arb_busy = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    busy_mode = 0; mready_mode = 2;
    push_words(1, 1'b0);
    for (int i = 0; i < 40 && wr_cnt == 0; i++) step();
    check("p6_first_wr_addr", 32'(first_wr_addr), 0);
    drain("p6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
